// File: rtl/dense_pkg.sv
// Shared constants and width helpers for the dense-stage feed path.
package dense_pkg;

    localparam int DENSE_DATA_WIDTH = 8;
    localparam int DENSE_NUMI_ONCE  = 24;
    localparam int DENSE_FRAME_LEN  = 72;

    // Index width for a counter over n positions, never narrower than 1 bit.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 32'sd1) begin
            w = 32'sd1;
        end
        return w;
    endfunction

    function automatic int lane_width(input int numi_once);
        return idx_width(numi_once);
    endfunction

    function automatic int fcnt_width(input int frame_len);
        return idx_width(frame_len);
    endfunction

endpackage

// File: rtl/dense_feed_frame_cnt.sv
// Frame element counter for dense_feed_packer: tracks position within the
// frame, flags the terminating element and, when DENSE_FEED_FRAME_CHECK_EN
// is defined, flags frame-length violations on that element.
module dense_feed_frame_cnt
    import dense_pkg::*;
#(
    parameter int FRAME_LEN = DENSE_FRAME_LEN,
    parameter int FCNT_W    = fcnt_width(DENSE_FRAME_LEN)
) (
    input  logic clk,
    input  logic rst,
    input  logic accept,
    input  logic last_i,
    output logic frame_end,
    output logic frame_err
);

    logic [FCNT_W-1:0] fcnt_r;
    logic              at_max_s;
    logic              frame_end_s;

    // Termination decode: explicit last or the element count hitting its cap.
    always_comb begin
        at_max_s    = (fcnt_r == FCNT_W'(FRAME_LEN - 1));
        frame_end_s = 1'b0;
        if (accept) begin
            frame_end_s = last_i | at_max_s;
        end else begin
            frame_end_s = 1'b0;
        end
    end

    // Frame position: advances per accepted element, restarts after termination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_r <= {FCNT_W{1'b0}};
        end else if (accept) begin
            if (frame_end_s) begin
                fcnt_r <= {FCNT_W{1'b0}};
            end else begin
                fcnt_r <= fcnt_r + FCNT_W'(1);
            end
        end else begin
            fcnt_r <= fcnt_r;
        end
    end

    assign frame_end = frame_end_s;

`ifdef DENSE_FEED_FRAME_CHECK_EN
    logic frame_err_s;

    // Error when a frame ends by last_i early, or reaches full length without last_i.
    always_comb begin
        frame_err_s = 1'b0;
        if (frame_end_s) begin
            frame_err_s = last_i ^ at_max_s;
        end else begin
            frame_err_s = 1'b0;
        end
    end

    assign frame_err = frame_err_s;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: rtl/dense_feed_packer.sv
// Width up-converter feeding the dense classifier: packs NUMI_ONCE elements
// of DATA_WIDTH bits into one wide beat with frame delimiting. Never stalls.
// Optional frame-length checking is enabled by defining DENSE_FEED_FRAME_CHECK_EN.
module dense_feed_packer
    import dense_pkg::*;
#(
    parameter int DATA_WIDTH = DENSE_DATA_WIDTH,
    parameter int NUMI_ONCE  = DENSE_NUMI_ONCE,
    parameter int FRAME_LEN  = DENSE_FRAME_LEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           data_i,
    input  logic                            valid_i,
    input  logic                            last_i,
    output logic [DATA_WIDTH*NUMI_ONCE-1:0] data_o,
    output logic                            valid_o,
    output logic                            last_o,
    output logic                            err_o
);

    localparam int LANE_W = lane_width(NUMI_ONCE);
    localparam int FCNT_W = fcnt_width(FRAME_LEN);
    localparam int BEAT_W = DATA_WIDTH * NUMI_ONCE;

    logic [BEAT_W-1:0] acc_r;
    logic [LANE_W-1:0] lane_r;
    logic [BEAT_W-1:0] merged_s;
    logic              lane_end_s;
    logic              close_s;
    logic              frame_end_s;
    logic              frame_err_s;

    dense_feed_frame_cnt #(
        .FRAME_LEN (FRAME_LEN),
        .FCNT_W    (FCNT_W)
    ) u_frame_cnt (
        .clk       (clk),
        .rst       (rst),
        .accept    (valid_i),
        .last_i    (last_i),
        .frame_end (frame_end_s),
        .frame_err (frame_err_s)
    );

    // Merge the incoming element into its lane and decide whether the beat closes.
    always_comb begin
        merged_s = acc_r;
        for (int k = 0; k < NUMI_ONCE; k++) begin
            if (lane_r == LANE_W'(k)) begin
                merged_s[k*DATA_WIDTH +: DATA_WIDTH] = data_i;
            end else begin
                merged_s[k*DATA_WIDTH +: DATA_WIDTH] = acc_r[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        lane_end_s = (lane_r == LANE_W'(NUMI_ONCE - 1));
        close_s    = valid_i & (lane_end_s | frame_end_s);
    end

    // Accumulation lanes and lane pointer; cleared on close so short beats zero-fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r  <= {BEAT_W{1'b0}};
            lane_r <= {LANE_W{1'b0}};
        end else if (valid_i) begin
            if (close_s) begin
                acc_r  <= {BEAT_W{1'b0}};
                lane_r <= {LANE_W{1'b0}};
            end else begin
                acc_r  <= merged_s;
                lane_r <= lane_r + LANE_W'(1);
            end
        end else begin
            acc_r  <= acc_r;
            lane_r <= lane_r;
        end
    end

    // Output beat register: data holds between beats, flags pulse with valid_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o  <= {BEAT_W{1'b0}};
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            valid_o <= close_s;
            last_o  <= close_s & frame_end_s;
            err_o   <= close_s & frame_err_s;
            if (close_s) begin
                data_o <= merged_s;
            end else begin
                data_o <= data_o;
            end
        end
    end

endmodule
